// File: rtl/fft_pkg.sv
// Shared FFT datapath constants: default widths, N=8 twiddles and width helpers
// used by the butterfly and the complex multiplier.
package fft_pkg;

  localparam int DW_DEF = 16;
  localparam int TW_DEF = 16;

  // W8^k = exp(-j*2*pi*k/8) in Q1.15, k = 0..3
  localparam logic [15:0] W8_RE [4] = '{16'h7FFF, 16'h5A82, 16'h0000, 16'hA57E};
  localparam logic [15:0] W8_IM [4] = '{16'h0000, 16'hA57E, 16'h8000, 16'hA57E};

  // Full-precision complex product width, post-round width and saturated product width
  function automatic int prod_w(input int dw, input int tw);
    return dw + tw + 1;
  endfunction

  function automatic int rnd_w(input int dw);
    return dw + 2;
  endfunction

  function automatic int psat_w(input int dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/cmul_rnd.sv
// Registered complex multiply B*W with round-half-up, saturation to DW+1 bits,
// twiddle bypass (W = +1 exactly) and a hold enable.
module cmul_rnd
  import fft_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          bypass,
  input  logic [DW-1:0] br,
  input  logic [DW-1:0] bi,
  input  logic [TW-1:0] wr,
  input  logic [TW-1:0] wi,
  output logic [DW:0]   pr,
  output logic [DW:0]   pi,
  output logic          sat
);
  localparam int PW = prod_w(DW, TW);
  localparam int RW = rnd_w(DW);
  localparam int QW = psat_w(DW);
  localparam logic signed [PW-1:0] HALF = {{(PW-TW+1){1'b0}}, 1'b1, {(TW-2){1'b0}}};

  logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x, full_r, full_i;
  logic [RW-1:0] rnd_r, rnd_i;
  logic [QW-1:0] pr_d, pi_d, pr_q, pi_q;
  logic sat_d, sat_q;

  function automatic logic over(input logic [RW-1:0] v);
    return v[RW-1] != v[RW-2];
  endfunction

  function automatic logic [QW-1:0] clamp(input logic [RW-1:0] v);
    if (!over(v)) return v[QW-1:0];
    return v[RW-1] ? {1'b1, {(QW-1){1'b0}}} : {1'b0, {(QW-1){1'b1}}};
  endfunction

  // NOTE: every variable gets a value before any branch, so no latch is inferred.
  always_comb begin
    br_x   = {{(PW-DW){br[DW-1]}}, br};
    bi_x   = {{(PW-DW){bi[DW-1]}}, bi};
    wr_x   = {{(PW-TW){wr[TW-1]}}, wr};
    wi_x   = {{(PW-TW){wi[TW-1]}}, wi};
    full_r = br_x * wr_x - bi_x * wi_x + HALF;
    full_i = br_x * wi_x + bi_x * wr_x + HALF;
    rnd_r  = RW'(full_r >>> (TW-1));
    rnd_i  = RW'(full_i >>> (TW-1));
    pr_d   = clamp(rnd_r);
    pi_d   = clamp(rnd_i);
    sat_d  = over(rnd_r) | over(rnd_i);
    if (bypass) begin
      pr_d  = {br[DW-1], br};
      pi_d  = {bi[DW-1], bi};
      sat_d = 1'b0;
    end
    if (!en) begin
      pr_d  = pr_q;
      pi_d  = pi_q;
      sat_d = sat_q;
    end
  end

  // NOTE: datapath registers are reset too, so outputs read as zero straight after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pr_q  <= '0;
      pi_q  <= '0;
      sat_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      pr_q  <= pr_d;
      pi_q  <= pi_d;
      sat_q <= sat_d;
    end
  end

  assign pr  = pr_q;
  assign pi  = pi_q;
  assign sat = sat_q;

endmodule

// File: rtl/bf2_pipe.sv
// Three-stage radix-2 DIT butterfly X = A + W*B, Y = A - W*B with valid/ready,
// per-sample scale and twiddle bypass, saturation and a sticky overflow flag.
module bf2_pipe
  import fft_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] ar,
  input  logic [DW-1:0] ai,
  input  logic [DW-1:0] br,
  input  logic [DW-1:0] bi,
  input  logic [TW-1:0] wr,
  input  logic [TW-1:0] wi,
  input  logic          tw_bypass,
  input  logic          scale,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] xr,
  output logic [DW-1:0] xi,
  output logic [DW-1:0] yr,
  output logic [DW-1:0] yi,
  output logic          ovf,
  input  logic          ovf_clr
);
  localparam int SW = rnd_w(DW);
  localparam logic signed [SW-1:0] ONE = {{(SW-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [DW-1:0] ar, ai, br, bi;
    logic [TW-1:0] wr, wi;
    logic          bypass, scale, valid;
  } s1_t;

  typedef struct packed {
    logic [DW-1:0] ar, ai;
    logic          scale, valid;
  } s2_t;

  typedef struct packed {
    logic [DW-1:0] xr, xi, yr, yi;
    logic          valid;
  } s3_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  logic ovf_d, ovf_q, en, sat2, sat3;
  logic [DW:0] p_r, p_i;
  logic signed [SW-1:0] s_xr, s_xi, s_yr, s_yi;

  function automatic logic over(input logic [SW-1:0] v);
    return !((v[SW-1:DW-1] == '0) || (v[SW-1:DW-1] == '1));
  endfunction

  function automatic logic [DW-1:0] clamp(input logic [SW-1:0] v);
    if (!over(v)) return v[DW-1:0];
    return v[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  endfunction

  cmul_rnd #(.DW(DW), .TW(TW)) u_cmul (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .bypass (s1_q.bypass),
    .br     (s1_q.br),
    .bi     (s1_q.bi),
    .wr     (s1_q.wr),
    .wi     (s1_q.wi),
    .pr     (p_r),
    .pi     (p_i),
    .sat    (sat2)
  );

  always_comb begin
    // Single stall signal: the whole pipe moves or holds together.
    en   = !s3_q.valid || out_ready;
    s1_d = s1_q;
    s2_d = s2_q;
    s3_d = s3_q;

    s_xr = {{2{s2_q.ar[DW-1]}}, s2_q.ar} + {p_r[DW], p_r};
    s_xi = {{2{s2_q.ai[DW-1]}}, s2_q.ai} + {p_i[DW], p_i};
    s_yr = {{2{s2_q.ar[DW-1]}}, s2_q.ar} - {p_r[DW], p_r};
    s_yi = {{2{s2_q.ai[DW-1]}}, s2_q.ai} - {p_i[DW], p_i};
    if (s2_q.scale) begin
      s_xr = (s_xr + ONE) >>> 1;
      s_xi = (s_xi + ONE) >>> 1;
      s_yr = (s_yr + ONE) >>> 1;
      s_yi = (s_yi + ONE) >>> 1;
    end
    sat3 = over(s_xr) | over(s_xi) | over(s_yr) | over(s_yi);

    // Clear loses to a set arriving in the same cycle.
    ovf_d = ovf_q & ~ovf_clr;
    if (en) begin
      s1_d = '{ar: ar, ai: ai, br: br, bi: bi, wr: wr, wi: wi,
               bypass: tw_bypass, scale: scale, valid: in_valid};
      s2_d = '{ar: s1_q.ar, ai: s1_q.ai, scale: s1_q.scale, valid: s1_q.valid};
      s3_d = '{xr: clamp(s_xr), xi: clamp(s_xi), yr: clamp(s_yr), yi: clamp(s_yi),
               valid: s2_q.valid};
      if (s2_q.valid && (sat2 || sat3)) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      ovf_q <= ovf_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = s3_q.valid;
  assign xr        = s3_q.xr;
  assign xi        = s3_q.xi;
  assign yr        = s3_q.yr;
  assign yi        = s3_q.yi;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bf2_pipe.sv
// Self-checking bench for bf2_pipe: directed cases plus randomized traffic scored
// against an integer-arithmetic butterfly model.
module tb_bf2_pipe;
  import fft_pkg::*;

  localparam int DW = 16;
  localparam int TW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, ovf, ovf_clr = 1'b0;
  logic tw_bypass = 1'b0, scale = 1'b0;
  logic signed [DW-1:0] ar = '0, ai = '0, br = '0, bi = '0;
  logic signed [TW-1:0] wr = '0, wi = '0;
  logic signed [DW-1:0] xr, xi, yr, yi;

  bf2_pipe #(.DW(DW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ar(ar), .ai(ai), .br(br), .bi(bi), .wr(wr), .wi(wi),
    .tw_bypass(tw_bypass), .scale(scale), .out_valid(out_valid), .out_ready(out_ready),
    .xr(xr), .xi(xi), .yr(yr), .yi(yi), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int xr, xi, yr, yi;
    bit sat;
    int acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t fixed_e;
  bit   use_fixed = 1'b0, check_lat = 1'b0, track_ovf = 1'b0, sticky = 1'b0;
  int   total = 0, bad = 0, cyc = 0, delivered = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint clampv(input longint v, input int bits, inout bit s);
    longint lo, hi;
    lo = -(64'sd1 <<< (bits - 1));
    hi = -lo - 1;
    if (v > hi) begin s = 1'b1; return hi; end
    if (v < lo) begin s = 1'b1; return lo; end
    return v;
  endfunction

  // Butterfly from first principles: exact product, round half-up, clamps.
  task automatic model(input int a_r, a_i, b_r, b_i, w_r, w_i, input bit byp, scl,
                       output exp_t e);
    longint p_r, p_i;
    longint s[4];
    bit st;
    st = 1'b0;
    if (byp) begin
      p_r = b_r;
      p_i = b_i;
    end else begin
      p_r = (longint'(b_r) * w_r - longint'(b_i) * w_i + (64'sd1 <<< (TW-2))) >>> (TW-1);
      p_i = (longint'(b_r) * w_i + longint'(b_i) * w_r + (64'sd1 <<< (TW-2))) >>> (TW-1);
      p_r = clampv(p_r, DW + 1, st);
      p_i = clampv(p_i, DW + 1, st);
    end
    s[0] = a_r + p_r;
    s[1] = a_i + p_i;
    s[2] = a_r - p_r;
    s[3] = a_i - p_i;
    for (int k = 0; k < 4; k++) begin
      if (scl) s[k] = (s[k] + 1) >>> 1;
      s[k] = clampv(s[k], DW, st);
    end
    e.xr = int'(s[0]);
    e.xi = int'(s[1]);
    e.yr = int'(s[2]);
    e.yi = int'(s[3]);
    e.sat = st;
    e.acc = 0;
  endtask

  // One clock: score transfers at the falling edge, then step past the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (in_valid && in_ready) begin
      if (use_fixed) e = fixed_e;
      else model(ar, ai, br, bi, wr, wi, tw_bypass, scale, e);
      e.acc = cyc;
      exp_q.push_back(e);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("xr", xr, e.xr);
        check("xi", xi, e.xi);
        check("yr", yr, e.yr);
        check("yi", yi, e.yi);
        delivered++;
        if (check_lat) check("latency", cyc - e.acc, 3);
        if (track_ovf) begin
          sticky |= e.sat;
          check("ovf_sticky", ovf, sticky);
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cycle();
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic send_fixed(input int a_r, a_i, b_r, b_i, input int e_xr, e_xi, e_yr, e_yi,
                            input bit e_sat);
    ar = a_r; ai = a_i; br = b_r; bi = b_i;
    fixed_e = '{xr: e_xr, xi: e_xi, yr: e_yr, yi: e_yi, sat: e_sat, acc: 0};
    use_fixed = 1'b1;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    bit seen;

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_xr", xr, 0);
    check("rst_yi", yi, 0);
    rst = 1'b0;
    @(posedge clk); cyc++; #1;
    check("in_ready_after_rst", in_ready, 1);
    cycle();
    cycle();
    rst = 1'b1;
    #2;
    check("idle_rst_out_valid", out_valid, 0);
    check("idle_rst_xi", xi, 0);
    check("idle_rst_yr", yr, 0);
    check("idle_rst_ovf", ovf, 0);
    rst = 1'b0;
    #1;
    check("idle_rst_in_ready", in_ready, 1);

    // Bypass, no scale
    check_lat = 1'b1;
    tw_bypass = 1'b1;
    scale = 1'b0;
    send_fixed(100, -50, 30, 20, 130, -30, 70, -70, 1'b0);
    drain("bypass", 8);
    check("bypass_single_valid", out_valid, 0);

    // Twiddle W8^1
    tw_bypass = 1'b0;
    wr = W8_RE[1];
    wi = W8_IM[1];
    send_fixed(0, 0, 1000, 0, 707, -707, -707, 707, 1'b0);
    drain("twiddle", 8);

    // Saturation, then clear and scaled
    tw_bypass = 1'b1;
    send_fixed(32767, 0, 1, 0, 32767, 0, 32766, 0, 1'b1);
    drain("sat", 8);
    check("sat_ovf_set", ovf, 1);
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 0);
    scale = 1'b1;
    send_fixed(32767, 0, 1, 0, 16384, 0, 16383, 0, 1'b0);
    drain("scaled", 8);
    check("scaled_ovf_clear", ovf, 0);
    scale = 1'b0;

    // Backpressure: 5 samples, 4-cycle stall after first out_valid
    check_lat = 1'b0;
    d0 = delivered;
    br = '0;
    bi = '0;
    ai = '0;
    use_fixed = 1'b1;
    in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      ar = k;
      fixed_e = '{xr: k, xi: 0, yr: k, yi: 0, sat: 1'b0, acc: 0};
      cycle();
    end
    ar = 4;
    fixed_e = '{xr: 4, xi: 0, yr: 4, yi: 0, sat: 1'b0, acc: 0};
    check("bp_first_valid", out_valid, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_in_ready_low", in_ready, 0);
      check("bp_out_valid_held", out_valid, 1);
      check("bp_xr_held", xr, 1);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    ar = 5;
    fixed_e = '{xr: 5, xi: 0, yr: 5, yi: 0, sat: 1'b0, acc: 0};
    cycle();
    in_valid = 1'b0;
    drain("bp", 12);
    check("bp_count", delivered - d0, 5);

    // Reset mid-stream with ovf previously set
    send_fixed(-32768, 0, 1, 0, -32767, 0, -32768, 0, 1'b1);
    send_fixed(-32768, 0, 1, 0, -32767, 0, -32768, 0, 1'b1);
    drain("presat", 8);
    check("presat_ovf", ovf, 1);
    in_valid = 1'b1;
    ar = 11;
    fixed_e = '{xr: 11, xi: 0, yr: 11, yi: 0, sat: 1'b0, acc: 0};
    cycle();
    ar = 12;
    cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_out_valid", out_valid, 0);
    rst = 1'b0;
    exp_q.delete();
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen = 1'b1;
      cycle();
    end
    check("mid_rst_no_output", seen, 0);
    check("mid_rst_ovf_after", ovf, 0);
    check_lat = 1'b1;
    send_fixed(7, 3, 2, -1, 9, 2, 5, 4, 1'b0);
    drain("post_rst", 8);

    // Randomized traffic against the model
    check_lat = 1'b0;
    use_fixed = 1'b0;
    track_ovf = 1'b1;
    sticky = 1'b0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tw_bypass = ($urandom_range(0, 4) == 0);
      scale     = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) begin
        ar = 16'sh7FFF; ai = 16'sh8000; br = 16'sh8000; bi = 16'sh8000;
      end else if ($urandom_range(0, 1) == 0) begin
        ar = $urandom; ai = $urandom; br = $urandom; bi = $urandom;
      end else begin
        ar = DW'($urandom_range(0, 4000)) - 16'sd2000;
        ai = DW'($urandom_range(0, 4000)) - 16'sd2000;
        br = DW'($urandom_range(0, 4000)) - 16'sd2000;
        bi = DW'($urandom_range(0, 4000)) - 16'sd2000;
      end
      if ($urandom_range(0, 1) == 0) begin
        wr = W8_RE[$urandom_range(0, 3)];
        wi = W8_IM[$urandom_range(0, 3)];
      end else begin
        wr = $urandom;
        wi = $urandom;
      end
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("random", 20);
    check("random_ovf_final", ovf, sticky);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bf2_pipe.md
Name: bf2_pipe

Overview:
- Parametrised radix-2 DIT butterfly for the FFT datapath; successor to the fixed 16-bit registered add/sub butterfly.
- Computes X = A + W·B and Y = A − W·B, where W is a complex twiddle. It has a 3-stage pipeline, a valid/ready handshake with backpressure, optional 1/2 scaling per stage, saturation and a sticky overflow flag.
- One instance per butterfly slot in the 8-point (and larger) FFT stage arrays.

Parameters:
- DW, 16, data width (signed two's complement) of each real/imag part, input and output.
- TW, 16, twiddle width; twiddles are signed Q1.(TW-1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input sample pair valid.
- in_ready  out  1  block can accept input this cycle.
- ar, ai  in  DW each  A real/imag.
- br, bi  in  DW each  B real/imag.
- wr, wi  in  TW each  twiddle real/imag, Q1.(TW-1).
- tw_bypass  in  1  1: W treated as exactly +1 (wr/wi ignored).
- scale  in  1  1: outputs divided by 2 with rounding.
- out_valid  out  1  output pair valid.
- out_ready  in  1  downstream accepts output.
- xr, xi, yr, yi  out  DW each  X and Y real/imag.
- ovf  out  1  sticky saturation flag.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset (async, rst=1): all pipeline valid bits 0, all data registers 0, xr/xi/yr/yi=0, out_valid=0, ovf=0. in_ready=1 while rst=0 and the pipe is empty.
- Global advance enable en = !out_valid | out_ready; in_ready = en (combinational). All stages shift only when en=1; otherwise every register holds. No bubble collapsing.
- Transfer rules: input transfers when in_valid & in_ready; output transfers when out_valid & out_ready.
- Control capture: tw_bypass and scale are captured with the data in S1 and travel down the pipe; they are per-sample.
- S1: register A, B, W, tw_bypass, scale and valid.
- S2, complex multiply:
  - pr = br·wr − bi·wi and pi = br·wi + bi·wr, at full precision (DW+TW+1 bits).
  - Round half-up: add 2^(TW-2), then arithmetic shift right by TW-1.
  - Saturate to DW+1 bits.
  - If tw_bypass: P = sign-extended B exactly.
  - Register P, A, scale and valid.
  - A saturation event here is recorded with the sample.
- S3, add/sub:
  - sx = A + P and sy = A − P in DW+2 bits.
  - If scale: s = (s + 1) >>> 1, then saturate to DW.
  - Else: saturate s to DW.
  - Register the outputs; out_valid is the S3 valid.
- Latency: 3 cycles from input transfer to out_valid with no backpressure; throughput 1 pair/cycle.
- Saturation: values clamp to +2^(DW-1)−1 / −2^(DW-1).
- ovf: set on the cycle a sample with any S2 or S3 saturation enters the S3 output register. Cleared by ovf_clr; if set and clear occur in the same cycle, set wins.
- Reset mid-stream: in-flight samples are discarded, ovf cleared; no output is produced for them.

Decomposition:
- Shared package fft_pkg holds:
  - DW_DEF=16, TW_DEF=16.
  - The N=8 twiddle constants W8^0..W8^3 (e.g. W8^1 = 0x5A82, 0xA57E).
  - Saturate and round-half-up constant widths.
- One sub-module: cmul_rnd. It is the complex multiply plus round plus saturate to DW+1, with a bypass input and a hold enable. It forms S2 and is reused later by the twiddle-rotation stage.

Test Plan (DW=16, TW=16):
- Reset: assert rst mid-idle → all outputs 0, out_valid=0, ovf=0; after release in_ready=1.
- Bypass, no scale: A=(100,−50), B=(30,20) → 3 cycles later X=(130,−30), Y=(70,−70), out_valid=1 for one cycle with out_ready=1.
- Twiddle: A=(0,0), B=(1000,0), W=(0x5A82,0xA57E), scale=0 → X=(707,−707), Y=(−707,707).
- Saturation/scale:
  - bypass, A=(32767,0), B=(1,0), scale=0 → xr=32767, ovf=1.
  - Then ovf_clr, scale=1, same data → xr=16384, yr=16383, ovf stays 0.
- Backpressure: stream 5 bypass samples A=(k,0), B=(0,0), k=1..5; hold out_ready=0 for 4 cycles after the first out_valid → in_ready=0 while stalled, outputs held stable, all 5 delivered in order xr=1..5, none lost or duplicated.
- Reset mid-stream: 2 samples in flight, pulse rst → out_valid never asserts for them; ovf=0; next sample appears 3 cycles after its acceptance.
